// File: rtl/i2s_audio_pkg.sv
// Shared I2S audio constants, slot map and receiver FSM state type.
// Used by the receiver RTL and by the transmitter bench models.
package i2s_audio_pkg;

  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned SLOT_W   = 7;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t FRAME_LEN    = 7'd50;
  localparam slot_t FRAME_MIN    = FRAME_LEN;
  localparam slot_t FRAME_MAX    = 7'd64;
  localparam slot_t SLOT_L_FIRST = 7'd1;
  localparam slot_t SLOT_RISE    = 7'd25;
  localparam slot_t SLOT_R_FIRST = 7'd26;
  localparam slot_t SLOT_R_LAST  = 7'd49;

  typedef enum logic [2:0] {
    RX_HUNT,
    RX_LEFT,
    RX_GUARD,
    RX_RIGHT,
    RX_TAIL
  } rx_state_e;

  // Slot counter never wraps; it parks at FRAME_MAX.
  function automatic slot_t slot_sat_inc(input slot_t s);
    return (s == FRAME_MAX) ? s : s + 7'd1;
  endfunction

endpackage

// File: rtl/i2s_rx_edge_det.sv
// Input register for SDATA/LRCLK plus previous-LRCLK stage; produces
// LRCLK fall/rise strobes from the registered values.
module i2s_rx_edge_det (
  input  logic i2s_1m_clk,
  input  logic RSTn,
  input  logic I2S_SDATA,
  input  logic I2S_LRCLK,
  output logic sdata_q,
  output logic lrclk_q,
  output logic lrclk_fall,
  output logic lrclk_rise
);

  logic lrclk_prev;

  always_ff @(posedge i2s_1m_clk or negedge RSTn) begin
    if (!RSTn) begin
      sdata_q    <= 1'b0;
      lrclk_q    <= 1'b0;
      lrclk_prev <= 1'b0;
    end else begin
      sdata_q    <= I2S_SDATA;
      lrclk_q    <= I2S_LRCLK;
      lrclk_prev <= lrclk_q;
    end
  end

  assign lrclk_fall = lrclk_prev & ~lrclk_q;
  assign lrclk_rise = ~lrclk_prev & lrclk_q;

endmodule

// File: rtl/i2s_rx_deser.sv
// I2S serial-to-parallel receiver for the 50..64-slot stereo frame.
// Optional guard-bit check enabled by defining I2S_RX_GUARD_CHK_EN.
module i2s_rx_deser
  import i2s_audio_pkg::*;
(
  input  logic                i2s_1m_clk,
  input  logic                RSTn,
  input  logic                I2S_SDATA,
  input  logic                I2S_LRCLK,
  output logic [SAMPLE_W-1:0] rx_ldata,
  output logic [SAMPLE_W-1:0] rx_rdata,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                rx_overrun,
  output logic                frame_err,
  output logic                locked
);

  logic                sdata_q;
  logic                lrclk_q;
  logic                lrclk_fall;
  logic                lrclk_rise;
  rx_state_e           state;
  slot_t               slot;
  slot_t               slot_cur;
  logic [SAMPLE_W-1:0] l_sr;
  logic [SAMPLE_W-1:0] r_sr;
`ifdef I2S_RX_GUARD_CHK_EN
  logic                guard_bit;
`endif

  i2s_rx_edge_det u_edge_det (
    .i2s_1m_clk (i2s_1m_clk),
    .RSTn       (RSTn),
    .I2S_SDATA  (I2S_SDATA),
    .I2S_LRCLK  (I2S_LRCLK),
    .sdata_q    (sdata_q),
    .lrclk_q    (lrclk_q),
    .lrclk_fall (lrclk_fall),
    .lrclk_rise (lrclk_rise)
  );

  // slot holds the last consumed slot index; slot_cur is the one in sdata_q now.
  assign slot_cur = slot_sat_inc(slot);

  always_ff @(posedge i2s_1m_clk or negedge RSTn) begin
    if (!RSTn) begin
      state      <= RX_HUNT;
      slot       <= '0;
      l_sr       <= '0;
      r_sr       <= '0;
      rx_ldata   <= '0;
      rx_rdata   <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
`ifdef I2S_RX_GUARD_CHK_EN
      guard_bit  <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      slot      <= slot_cur;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      if (state == RX_HUNT) begin
        slot   <= '0;
        locked <= 1'b0;
        if (lrclk_fall)
          state <= RX_LEFT;
      end else if (lrclk_fall) begin
        // Any fall restarts the frame at slot 0; only a tail fall is clean.
        slot  <= '0;
        state <= RX_LEFT;
        l_sr  <= '0;
        r_sr  <= '0;
        if (state == RX_TAIL && slot >= FRAME_MIN - 7'd1) begin
          locked <= 1'b1;
        end else begin
          frame_err <= 1'b1;
          locked    <= 1'b0;
        end
      end else if (lrclk_rise && locked && slot_cur != SLOT_RISE) begin
        frame_err <= 1'b1;
        locked    <= 1'b0;
        state     <= RX_HUNT;
      end else begin
        case (state)
          RX_LEFT: begin
            if (slot_cur >= SLOT_L_FIRST)
              l_sr <= {l_sr[SAMPLE_W-2:0], sdata_q};
            if (slot_cur == SLOT_RISE - 7'd1)
              state <= RX_GUARD;
          end
          RX_GUARD: begin
            if (!lrclk_q) begin
              frame_err <= 1'b1;
              locked    <= 1'b0;
              state     <= RX_HUNT;
            end else begin
`ifdef I2S_RX_GUARD_CHK_EN
              guard_bit <= sdata_q;
`endif
              state <= RX_RIGHT;
            end
          end
          RX_RIGHT: begin
            r_sr <= {r_sr[SAMPLE_W-2:0], sdata_q};
`ifdef I2S_RX_GUARD_CHK_EN
            if (slot_cur == SLOT_R_FIRST && sdata_q != guard_bit)
              frame_err <= 1'b1;
`endif
            if (slot_cur == SLOT_R_LAST) begin
              rx_ldata <= l_sr;
              rx_rdata <= {r_sr[SAMPLE_W-2:0], sdata_q};
              rx_valid <= 1'b1;
              if (rx_valid && !rx_ready)
                rx_overrun <= 1'b1;
              state <= RX_TAIL;
            end
          end
          RX_TAIL: begin
            if (slot == FRAME_MAX - 7'd1) begin
              frame_err <= 1'b1;
              locked    <= 1'b0;
              state     <= RX_HUNT;
            end
          end
          default: state <= RX_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Directed/random frame-level bench for i2s_rx_deser with a transmitter
// model and a per-frame expectation model (pairs, frame_err count, lock).
module tb_i2s_rx_deser;

  logic        i2s_1m_clk = 1'b0;
  logic        RSTn       = 1'b0;
  logic        I2S_SDATA  = 1'b0;
  logic        I2S_LRCLK  = 1'b1;
  logic        rx_ready   = 1'b1;
  logic [23:0] rx_ldata;
  logic [23:0] rx_rdata;
  logic        rx_valid;
  logic        rx_overrun;
  logic        frame_err;
  logic        locked;

  i2s_rx_deser dut (
    .i2s_1m_clk (i2s_1m_clk),
    .RSTn       (RSTn),
    .I2S_SDATA  (I2S_SDATA),
    .I2S_LRCLK  (I2S_LRCLK),
    .rx_ldata   (rx_ldata),
    .rx_rdata   (rx_rdata),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err),
    .locked     (locked)
  );

  always #5 i2s_1m_clk = ~i2s_1m_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Observed traffic, collected on the falling edge.
  logic [47:0] got_q[$];
  int          err_cnt  = 0;
  int          err_base = 0;

  always @(negedge i2s_1m_clk) begin
    if (frame_err) err_cnt++;
    if (rx_valid && rx_ready) got_q.push_back({rx_ldata, rx_rdata});
  end

  // Frame-level reference model state.
  logic [47:0] exp_q[$];
  logic        m_locked   = 1'b0;
  logic        m_pending  = 1'b0;
  logic        m_overrun  = 1'b0;
  logic [47:0] m_held     = '0;
  int          m_exp_errs = 0;
  logic        prev_r_lsb = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outcome of the previous frame, sampled a few slots into the next one.
  task automatic frame_checks();
    chk("locked", 64'(locked), 64'(m_locked));
    chk("frame_err_count", 64'(err_cnt - err_base), 64'(m_exp_errs));
    err_base = err_cnt;
    chk("pair_count", 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk("pair", 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    chk("overrun", 64'(rx_overrun), 64'(m_overrun));
    if (m_pending) begin
      chk("held_valid", 64'(rx_valid), 64'd1);
      chk("held_pair", 64'({rx_ldata, rx_rdata}), 64'(m_held));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i2s_1m_clk); #2;
      I2S_LRCLK = 1'b1;
      I2S_SDATA = 1'b0;
    end
  endtask

  // One transmitted frame of len slots starting at an LRCLK fall.
  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int len,
                            input bit flip, input int rst_at, input int rdy_slot,
                            input bit rdy_val);
    int errs;
    for (int k = 0; k < len; k++) begin
      @(posedge i2s_1m_clk); #2;
      I2S_LRCLK = (k >= 25);
      if (k == 0)       I2S_SDATA = prev_r_lsb;
      else if (k <= 24) I2S_SDATA = l[24-k];
      else if (k == 25) I2S_SDATA = r[23] ^ flip;
      else if (k <= 49) I2S_SDATA = r[49-k];
      else              I2S_SDATA = 1'b0;
      if (k == rdy_slot) begin
        rx_ready = rdy_val;
        if (rdy_val && m_pending) begin
          exp_q.push_back(m_held);
          m_pending = 1'b0;
        end
      end
      if (k == rst_at)     RSTn = 1'b0;
      if (k == rst_at + 1) RSTn = 1'b1;
      @(negedge i2s_1m_clk); #1;
      if (k == 3) frame_checks();
      if (k == rst_at)
        chk("reset_outputs",
            64'({rx_valid, rx_overrun, frame_err, locked, rx_ldata, rx_rdata}), 64'd0);
      if (k == rdy_slot + 1 && rdy_val)
        chk("accept_clears_valid", 64'(rx_valid), 64'd0);
      if ((k == 50 || k == 51) && len >= 52 && rx_ready && rst_at < 0)
        chk("valid_latency", 64'(rx_valid), 64'(k == 51));
    end
    prev_r_lsb = r[0];

    errs = 0;
    if (rst_at >= 0) begin
      m_locked  = 1'b0;
      m_pending = 1'b0;
      m_overrun = 1'b0;
    end else begin
      if (len < 50 || len > 64) begin
        errs     = 1;
        m_locked = 1'b0;
      end else begin
        m_locked = 1'b1;
      end
`ifdef I2S_RX_GUARD_CHK_EN
      if (flip && len >= 27) errs++;
`endif
      if (len >= 50) begin
        if (rx_ready) exp_q.push_back({l, r});
        else begin
          if (m_pending) m_overrun = 1'b1;
          m_pending = 1'b1;
          m_held    = {l, r};
        end
      end
    end
    m_exp_errs = errs;
  endtask

  task automatic rand_frame(input int len);
    send_frame(24'($urandom()), 24'($urandom()), len, 1'b0, -1, -1, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge i2s_1m_clk);
    @(negedge i2s_1m_clk); #1;
    chk("reset_state", 64'({rx_valid, rx_overrun, frame_err, locked, rx_ldata, rx_rdata}), 64'd0);
    @(posedge i2s_1m_clk); #2;
    RSTn = 1'b1;
    idle(3);

    // Nominal 50-slot frames
    send_frame(24'h123456, 24'hFEDCBA, 50, 1'b0, -1, -1, 1'b0);
    send_frame(24'h123456, 24'hFEDCBA, 50, 1'b0, -1, -1, 1'b0);
    rand_frame(50);
    rand_frame(50);

    // Longest legal frame, then one slot too long, then relock
    rand_frame(64);
    rand_frame(50);
    rand_frame(65);
    rand_frame(50);
    rand_frame(50);

    // Short frame: fall at slot 30
    rand_frame(30);
    rand_frame(50);
    rand_frame(50);

    // Back-pressure and overrun
    send_frame(24'd1, 24'd2, 50, 1'b0, -1, 5, 1'b0);
    send_frame(24'd3, 24'd4, 50, 1'b0, -1, -1, 1'b0);
    send_frame(24'($urandom()), 24'($urandom()), 50, 1'b0, -1, 5, 1'b1);
    rand_frame(57);

    // Reset in the middle of a frame
    send_frame(24'($urandom()), 24'($urandom()), 50, 1'b0, 12, -1, 1'b0);
    rand_frame(50);
    rand_frame(50);

    // Guard bit disagreeing with Rdata[23]
    send_frame(24'($urandom()), 24'h800000, 50, 1'b1, -1, -1, 1'b0);
    rand_frame(50);
    rand_frame(50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
